ppu_oam_port: RTL
=================

Name: ppu_oam_port

Overview:
- PPU-side responder for the CPU-bus OAM registers: OAMADDR ($2003) and OAMDATA ($2004), mirrored every 8 bytes across $2000-$3FFF.
- Owns the 256x8 sprite attribute memory (OAM). Receives the CPU's $2004 write stream, including the 256-byte OAM DMA burst (read page byte, write $2004).
- Provides CPU read-back of $2004 and a synchronous read port for the PPU sprite evaluator.

Parameters:
- P_DECODE_HI, 3'b001, required value of I_addr[15:13] for a PPU register hit.
- P_ATTR_MASK, 1, when 1, CPU reads of attribute bytes (oam_addr[1:0]==2) return bits 4:2 as 0.
- P_RENDER_INC4, 1, when 1, $2004 writes during rendering are dropped and oam_addr advances by 4.

Ports:
- I_clock  in  1  system clock
- I_reset  in  1  synchronous, active-high reset
- I_addr  in  16  CPU bus address
- I_wr_data  in  8  CPU bus write data
- I_rdwr  in  1  1=read, 0=write
- I_phy2  in  1  CPU phase-2 clock-enable level from the core
- O_rd_data  out  8  $2004 read data
- O_rd_hit  out  1  1 when the current bus cycle is a CPU read of $2004; bus mux enable
- I_rendering  in  1  PPU is in visible/pre-render fetch window
- I_oamaddr_clr  in  1  PPU request to zero oam_addr (sprite fetch ticks 257-320)
- I_ppu_addr  in  8  sprite evaluator read address
- O_ppu_data  out  8  sprite evaluator read data
- O_oam_addr  out  8  current OAMADDR, for debug and sprite-0 logic

Behaviour:
- Reset: I_reset is synchronous and active-high on clock I_clock.
  - On reset: oam_addr=0, last_phy2=0, O_rd_data=0, O_rd_hit=0, O_ppu_data=0, O_oam_addr=0.
  - OAM contents are not cleared.
- phy2 edge: last_phy2 is registered every clock. fall = last_phy2 & ~I_phy2. All CPU-side writes commit only on a fall clock, one commit per bus cycle.
- Decode: hit = I_addr[15:13]==P_DECODE_HI. Register select is I_addr[2:0]: 3 selects OAMADDR, 4 selects OAMDATA. All other selects are ignored by this block.
- Write to OAMADDR (fall, ~I_rdwr, sel 3): oam_addr <= I_wr_data.
- Write to OAMDATA (fall, ~I_rdwr, sel 4):
  - Not rendering: mem[oam_addr] <= I_wr_data, then oam_addr <= oam_addr+1 with 8-bit wrap (0xFF -> 0x00).
  - Rendering with P_RENDER_INC4=1: no memory write; oam_addr <= oam_addr+4 with wrap.
  - Rendering with P_RENDER_INC4=0: behaves as not rendering.
- Read OAMDATA (I_rdwr, sel 4):
  - O_rd_hit is combinational from the address decode.
  - O_rd_data is registered: mem[oam_addr] captured every clock, so latency is 1 clock. Valid from the 2nd clock of phy2 high.
  - Attribute masking applies when P_ATTR_MASK=1 and oam_addr[1:0]==2.
  - Reads never change oam_addr.
- PPU port: O_ppu_data <= mem[I_ppu_addr] every clock; 1-clock latency, no masking. The memory is true dual-read, single-write.
- I_oamaddr_clr: oam_addr <= 0 on any clock where it is high.
- Simultaneous events:
  - A CPU OAMADDR/OAMDATA commit on the same clock as I_oamaddr_clr: the CPU commit wins.
  - A write to mem[a] while the PPU reads address a: the PPU gets the old data; new data appears next clock.
- DMA stream: each push cycle (addr $2004, write) behaves exactly as a single OAMDATA write. 256 pushes starting at oam_addr=N fill all 256 bytes and leave oam_addr=N.
- Reset mid-burst: remaining pushes after reset release land from oam_addr=0. Bytes already written are kept.

Test Plan:
- Reset, then $2003<=0x00 and 256 DMA-style $2004 writes of data=i -> mem[i]==i for all i; oam_addr==0x00 at end; PPU port reads mem[0x7F]=0x7F with 1-clock latency.
- $2003<=0xFE, write 0xAA, 0xBB, 0xCC -> mem[0xFE]=0xAA, mem[0xFF]=0xBB, mem[0x00]=0xCC; oam_addr=0x01.
- $2003<=0x02, write 0xFF, $2003<=0x02, read $200C (mirror) -> O_rd_hit=1, O_rd_data=0xE3; with P_ATTR_MASK=0 -> 0xFF; oam_addr stays 0x02.
- I_rendering=1, $2003<=0x10, write 0x55 -> mem[0x10] unchanged, oam_addr=0x14.
- I_oamaddr_clr=1 on the same clock as a $2003<=0x40 commit -> oam_addr=0x40; clr alone next clock -> 0x00.
- Reset asserted after 100 DMA pushes starting at 0x00, then 156 more pushes -> mem[0..99] hold first-run data overwritten by pushes 0..99 of the second run; oam_addr=0x9C.

Source files
------------

// File: rtl/ppu_oam_port.sv
// PPU-side responder for OAMADDR ($2003) and OAMDATA ($2004), mirrored every
// 8 bytes across $2000-$3FFF. Owns the 256x8 sprite attribute memory, takes
// the CPU write stream (including OAM DMA bursts), returns $2004 read data and
// serves the sprite evaluator through a second synchronous read port.
module ppu_oam_port #(
   parameter logic [2:0] P_DECODE_HI   = 3'b001,
   parameter bit         P_ATTR_MASK   = 1'b1,
   parameter bit         P_RENDER_INC4 = 1'b1
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic [15:0] I_addr,
   input  logic [7:0]  I_wr_data,
   input  logic        I_rdwr,
   input  logic        I_phy2,
   output logic [7:0]  O_rd_data,
   output logic        O_rd_hit,
   input  logic        I_rendering,
   input  logic        I_oamaddr_clr,
   input  logic [7:0]  I_ppu_addr,
   output logic [7:0]  O_ppu_data,
   output logic [7:0]  O_oam_addr
);

   logic [7:0] mem [0:255];
   logic [7:0] oam_addr;
   logic       last_phy2;

   logic       fall;
   logic       hit;
   logic       sel_addr;
   logic       sel_data;
   logic       wr_oamaddr;
   logic       wr_oamdata;
   logic       drop_wr;
   logic       mem_we;
   logic [7:0] rd_next;

   // Address bits between the decode field and the register select are mirrors.
   logic       unused_addr_bits;
   assign unused_addr_bits = ^I_addr[12:3];

   // Bus decode, phy2 falling-edge detect and commit strobes.
   always_comb begin
      fall       = last_phy2 & ~I_phy2;
      hit        = (I_addr[15:13] == P_DECODE_HI);
      sel_addr   = (I_addr[2:0] == 3'd3);
      sel_data   = (I_addr[2:0] == 3'd4);
      wr_oamaddr = fall & ~I_rdwr & hit & sel_addr;
      wr_oamdata = fall & ~I_rdwr & hit & sel_data;
      drop_wr    = P_RENDER_INC4 & I_rendering;
      mem_we     = wr_oamdata & ~drop_wr & ~I_reset;
      O_rd_hit   = ~I_reset & hit & I_rdwr & sel_data;
      O_oam_addr = oam_addr;
   end

   // CPU read-back value, with attribute bits 4:2 forced low when masking.
   always_comb begin
      rd_next = mem[oam_addr];
      if (P_ATTR_MASK && (oam_addr[1:0] == 2'd2)) begin
         rd_next = rd_next & 8'hE3;
      end
   end

   // Previous phy2 level for edge detection.
   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         last_phy2 <= 1'b0;
      end else begin
         last_phy2 <= I_phy2;
      end
   end

   // OAMADDR update; a CPU commit takes priority over the PPU clear request.
   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         oam_addr <= '0;
      end else if (wr_oamaddr) begin
         oam_addr <= I_wr_data;
      end else if (wr_oamdata) begin
         oam_addr <= drop_wr ? oam_addr + 8'd4 : oam_addr + 8'd1;
      end else if (I_oamaddr_clr) begin
         oam_addr <= '0;
      end
   end

   // OAM write port; contents survive reset.
   always_ff @(posedge I_clock) begin
      if (mem_we) begin
         mem[oam_addr] <= I_wr_data;
      end
   end

   // Registered read ports: CPU $2004 data and sprite evaluator data.
   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         O_rd_data  <= '0;
         O_ppu_data <= '0;
      end else begin
         O_rd_data  <= rd_next;
         O_ppu_data <= mem[I_ppu_addr];
      end
   end

endmodule
